// File: rtl/shift_deser_if.sv
// shift_deser_if: bundles the serial input, output handshake and status
// signals of the shift_deser receiver.
//   master modport: the producer/consumer side (drives the bit stream,
//                   out_ready and ovf_clr; observes the word and status).
//   slave modport : the shift_deser block itself.
// Signals:
//   bit_valid, bit_in, sync  - serial stream and frame-alignment strobe
//   out_ready, ovf_clr       - consumer accept and overflow clear
//   data_out, out_valid      - assembled word and its valid flag
//   busy, overflow           - partial-word-in-progress and sticky drop flag
interface shift_deser_if #(
  parameter int DATA_W = 8
);
  logic              bit_valid;
  logic              bit_in;
  logic              sync;
  logic              out_ready;
  logic              ovf_clr;
  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic              busy;
  logic              overflow;

  modport master (
    output bit_valid, bit_in, sync, out_ready, ovf_clr,
    input  data_out, out_valid, busy, overflow
  );

  modport slave (
    input  bit_valid, bit_in, sync, out_ready, ovf_clr,
    output data_out, out_valid, busy, overflow
  );
endinterface

// File: rtl/shift_deser.sv
// shift_deser: serial-in/parallel-out receiver. Rebuilds DATA_W-bit words
// from a 1-bit stream (LSB-first by default, matching a right-shifting
// source), with sync-strobe frame alignment, a one-word output register
// behind a valid/ready handshake, and a sticky overflow flag for words that
// complete while the output register is still full.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - shift_deser_if.slave (stream in, word/status out)
// Parameters:
//   DATA_W    - word width (>= 2)
//   MSB_FIRST - 1: first received bit lands in bit DATA_W-1
//   SYNC_REQ  - 1: a word may only start on a bit with sync=1
module shift_deser #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b0,
  parameter bit SYNC_REQ  = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  shift_deser_if.slave   bus
);
  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [DATA_W-1:0] sreg_reg, sreg_next;
  logic [DATA_W-1:0] data_out_reg, data_out_next;
  logic              out_valid_reg, out_valid_next;
  logic              overflow_reg, overflow_next;

  logic              accept;
  logic              restart;
  logic              word_done;
  logic [DATA_W-1:0] sreg_base;
  logic [DATA_W-1:0] shifted;

  // A bit is taken mid-word, on a sync strobe, or anywhere when alignment
  // is not required.
  assign accept = bus.bit_valid &&
                  ((state_reg == SHIFT) || bus.sync || !SYNC_REQ);

  // A fresh word (from IDLE or a resync) shifts into a cleared register so
  // stale partial bits never leak into the new word.
  assign restart   = (state_reg == IDLE) || bus.sync;
  assign sreg_base = restart ? '0 : sreg_reg;

  always_comb begin
    shifted = '0;
    if (MSB_FIRST) begin
      shifted = {sreg_base[DATA_W-2:0], bus.bit_in};
    end else begin
      shifted = {bus.bit_in, sreg_base[DATA_W-1:1]};
    end
  end

  // Next-state logic for the word assembler.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sreg_next  = sreg_reg;
    word_done  = 1'b0;

    if (accept) begin
      sreg_next = shifted;
      if ((state_reg == SHIFT) && bus.sync) begin
        // Resync: current bit is the first bit of a new word.
        cnt_next   = CNT_W'(1);
        state_next = SHIFT;
      end else if (cnt_reg == LAST_CNT) begin
        word_done  = 1'b1;
        cnt_next   = '0;
        state_next = IDLE;
      end else begin
        cnt_next   = cnt_reg + CNT_W'(1);
        state_next = SHIFT;
      end
    end else if ((state_reg == SHIFT) && bus.sync) begin
      // Sync without data abandons the partial word.
      cnt_next   = '0;
      sreg_next  = '0;
      state_next = IDLE;
    end
  end

  // Output register, handshake and sticky overflow.
  always_comb begin
    data_out_next  = data_out_reg;
    out_valid_next = out_valid_reg;
    overflow_next  = overflow_reg & ~bus.ovf_clr;

    if (word_done) begin
      if (!out_valid_reg || bus.out_ready) begin
        // Drain and reload in one cycle keeps out_valid high.
        data_out_next  = shifted;
        out_valid_next = 1'b1;
      end else begin
        overflow_next  = 1'b1;
      end
    end else if (bus.out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      sreg_reg      <= '0;
      data_out_reg  <= '0;
      out_valid_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      sreg_reg      <= sreg_next;
      data_out_reg  <= data_out_next;
      out_valid_reg <= out_valid_next;
      overflow_reg  <= overflow_next;
    end
  end

  assign bus.data_out  = data_out_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.busy      = (state_reg == SHIFT);
  assign bus.overflow  = overflow_reg;
endmodule

// File: tb/tb_shift_deser.sv
// tb_shift_deser: directed bench for shift_deser. Two instances:
//   dut_a - LSB-first, sync required
//   dut_b - MSB-first, sync not required
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_shift_deser;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  shift_deser_if #(.DATA_W(8)) a_if ();
  shift_deser_if #(.DATA_W(8)) b_if ();

  shift_deser #(.DATA_W(8), .MSB_FIRST(1'b0), .SYNC_REQ(1'b1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if.slave)
  );

  shift_deser #(.DATA_W(8), .MSB_FIRST(1'b1), .SYNC_REQ(1'b0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if.slave)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic a_cyc(input logic bv, input logic bi, input logic sy,
                       input logic rdy, input logic clr);
    a_if.bit_valid = bv;
    a_if.bit_in    = bi;
    a_if.sync      = sy;
    a_if.out_ready = rdy;
    a_if.ovf_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic b_cyc(input logic bv, input logic bi, input logic sy,
                       input logic rdy, input logic clr);
    b_if.bit_valid = bv;
    b_if.bit_in    = bi;
    b_if.sync      = sy;
    b_if.out_ready = rdy;
    b_if.ovf_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  // Sends one LSB-first word to dut_a; counts busy-high and out_valid-high
  // samples taken after each of the first seven bits.
  task automatic a_word(input logic [7:0] d, input logic do_sync,
                        input logic rdy_body, input logic rdy_last,
                        input logic clr_last,
                        output int busy_hi, output int early);
    busy_hi = 0;
    early   = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        a_cyc(1'b1, d[i], 1'b0, rdy_last, clr_last);
      end else begin
        a_cyc(1'b1, d[i], do_sync && (i == 0), rdy_body, 1'b0);
        busy_hi += int'(a_if.busy);
        early   += int'(a_if.out_valid);
      end
    end
  endtask

  initial begin
    int bh, ev;
    logic [7:0] v;
    logic [7:0] src;

    a_if.bit_valid = 0; a_if.bit_in = 0; a_if.sync = 0;
    a_if.out_ready = 1; a_if.ovf_clr = 0;
    b_if.bit_valid = 0; b_if.bit_in = 0; b_if.sync = 0;
    b_if.out_ready = 1; b_if.ovf_clr = 0;

    // Reset state
    #2 rst_n = 1'b0;
    #20;
    check_val("rst a.data_out", 32'(a_if.data_out), 32'h0);
    check_val("rst a.flags", {29'd0, a_if.out_valid, a_if.busy, a_if.overflow}, 32'h0);
    check_val("rst b.flags", {29'd0, b_if.out_valid, b_if.busy, b_if.overflow}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // sync + 0x55 LSB-first, out_ready=1
    a_word(8'h55, 1'b1, 1'b1, 1'b1, 1'b0, bh, ev);
    check_val("w55 busy cycles", 32'(bh), 32'd7);
    check_val("w55 early valid", 32'(ev), 32'd0);
    check_val("w55 out_valid", 32'(a_if.out_valid), 32'h1);
    check_val("w55 data_out", 32'(a_if.data_out), 32'h55);
    check_val("w55 busy after last", 32'(a_if.busy), 32'h0);
    check_val("w55 overflow", 32'(a_if.overflow), 32'h0);
    a_cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("w55 drained", 32'(a_if.out_valid), 32'h0);

    // MSB-first with gaps, no sync needed (dut_b)
    v  = 8'hA3;
    ev = 0;
    for (int i = 0; i < 8; i++) begin
      b_cyc(1'b1, v[7-i], 1'b0, 1'b1, 1'b0);
      if (i < 7) ev += int'(b_if.out_valid);
      if (i == 1 || i == 3 || i == 4) begin
        b_cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        ev += int'(b_if.out_valid);
        if (i == 3) check_val("wA3 busy in gap", 32'(b_if.busy), 32'h1);
      end
    end
    check_val("wA3 early valid", 32'(ev), 32'd0);
    check_val("wA3 data_out", 32'(b_if.data_out), 32'hA3);
    check_val("wA3 out_valid", 32'(b_if.out_valid), 32'h1);
    b_cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("wA3 single word", 32'(b_if.out_valid), 32'h0);

    // Bits without sync are ignored in IDLE
    for (int i = 0; i < 3; i++) a_cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check_val("nosync busy", 32'(a_if.busy), 32'h0);
    check_val("nosync valid", 32'(a_if.out_valid), 32'h0);
    a_word(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, bh, ev);
    check_val("wFF data_out", 32'(a_if.data_out), 32'hFF);
    a_cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Resync: 4 bits of 0x0F abandoned by sync+0x3C
    v = 8'h0F;
    for (int i = 0; i < 4; i++) a_cyc(1'b1, v[i], i == 0, 1'b1, 1'b0);
    check_val("partial busy", 32'(a_if.busy), 32'h1);
    a_word(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, bh, ev);
    check_val("w3C early valid", 32'(ev), 32'd0);
    check_val("w3C data_out", 32'(a_if.data_out), 32'h3C);
    check_val("w3C overflow", 32'(a_if.overflow), 32'h0);
    a_cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // sync with bit_valid=0 in SHIFT drops back to IDLE
    for (int i = 0; i < 3; i++) a_cyc(1'b1, 1'b1, i == 0, 1'b1, 1'b0);
    a_cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_val("sync-idle busy", 32'(a_if.busy), 32'h0);
    a_cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check_val("post-abort ignored", 32'(a_if.busy), 32'h0);

    // Back-pressure: 0x11 held, 0x22 dropped
    a_word(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, bh, ev);
    check_val("w11 data_out", 32'(a_if.data_out), 32'h11);
    a_word(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, bh, ev);
    check_val("w22 dropped data", 32'(a_if.data_out), 32'h11);
    check_val("w22 overflow", 32'(a_if.overflow), 32'h1);
    a_cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_val("ovf_clr", 32'(a_if.overflow), 32'h0);
    check_val("ovf_clr valid held", 32'(a_if.out_valid), 32'h1);
    a_word(8'h33, 1'b1, 1'b0, 1'b1, 1'b0, bh, ev);
    check_val("w33 reload data", 32'(a_if.data_out), 32'h33);
    check_val("w33 reload valid", 32'(a_if.out_valid), 32'h1);
    check_val("w33 overflow", 32'(a_if.overflow), 32'h0);
    // Drop and clear in the same cycle: set wins
    a_word(8'h44, 1'b1, 1'b0, 1'b0, 1'b1, bh, ev);
    check_val("w44 set wins", 32'(a_if.overflow), 32'h1);
    check_val("w44 data held", 32'(a_if.data_out), 32'h33);

    // Asynchronous reset mid-word with a pending word and overflow set
    v = 8'h5A;
    for (int i = 0; i < 5; i++) a_cyc(1'b1, v[i], i == 0, 1'b0, 1'b0);
    check_val("pre-rst busy", 32'(a_if.busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_val("async rst data", 32'(a_if.data_out), 32'h0);
    check_val("async rst flags", {29'd0, a_if.out_valid, a_if.busy, a_if.overflow}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    a_word(8'h81, 1'b1, 1'b1, 1'b1, 1'b0, bh, ev);
    check_val("w81 data_out", 32'(a_if.data_out), 32'h81);
    check_val("w81 out_valid", 32'(a_if.out_valid), 32'h1);
    a_cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Loopback from a right-shifting source register
    src = 8'h55;
    for (int i = 0; i < 8; i++) begin
      a_cyc(1'b1, src[0], i == 0, 1'b1, 1'b0);
      src = {1'b0, src[7:1]};
    end
    check_val("loopback data", 32'(a_if.data_out), 32'h55);
    check_val("loopback valid", 32'(a_if.out_valid), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
